// File: rtl/xsim_dma_burst_client.sv
// Burst DMA initiator for the simulation word-level responder: splits burst commands into
// 32-bit read requests / write32 beats and returns read data through a credit-managed FIFO.
module xsim_dma_burst_client #(
  parameter int RFIFO_DEPTH = 4,
  parameter int BEATS_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [31:0]            cmd_handle,
  input  logic [31:0]            cmd_addr,
  input  logic [BEATS_WIDTH-1:0] cmd_beats,
  input  logic                   wdata_valid,
  output logic                   wdata_ready,
  input  logic [31:0]            wdata,
  output logic                   rdata_valid,
  input  logic                   rdata_ready,
  output logic [31:0]            rdata,
  output logic                   rdata_last,
  output logic                   done,
  output logic                   busy,
  input  logic                   dma_rdy_readrequest,
  output logic                   dma_en_readrequest,
  output logic [31:0]            dma_readrequest_addr,
  output logic [31:0]            dma_readrequest_handle,
  input  logic                   dma_rdy_readresponse,
  output logic                   dma_en_readresponse,
  input  logic [31:0]            dma_readresponse_data,
  output logic                   dma_en_write32,
  output logic [31:0]            dma_write32_addr,
  output logic [31:0]            dma_write32_handle,
  output logic [31:0]            dma_write32_data
);

  localparam int PW = $clog2(RFIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            handle_q, handle_d;
  logic [31:0]            req_addr_q, req_addr_d;
  logic [BEATS_WIDTH-1:0] req_left_q, req_left_d;
  logic [BEATS_WIDTH-1:0] resp_left_q, resp_left_d;
  logic [CW-1:0]          outstanding_q, outstanding_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [31:0]            fifo_data_q [RFIFO_DEPTH];
  logic                   fifo_last_q [RFIFO_DEPTH];

  logic issue, resp, wfire, push, pop;

  always_comb begin
    state_d       = state_q;
    handle_d      = handle_q;
    req_addr_d    = req_addr_q;
    req_left_d    = req_left_q;
    resp_left_d   = resp_left_q;
    issue         = 1'b0;
    resp          = 1'b0;
    wfire         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          handle_d    = cmd_handle;
          req_addr_d  = cmd_addr;
          req_left_d  = cmd_beats;
          resp_left_d = cmd_beats;
          // A zero-beat burst passes through READ/WRITE once with nothing to do,
          // so done lands two cycles after accept in both directions.
          state_d     = cmd_write ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        // Credit: never let in-flight requests plus buffered beats exceed the FIFO.
        issue = (req_left_q != '0) && dma_rdy_readrequest &&
                ((CW+1)'(outstanding_q) + (CW+1)'(count_q) < (CW+1)'(RFIFO_DEPTH));
        resp  = dma_rdy_readresponse;
        if (issue) begin
          req_addr_d = req_addr_q + 32'd4;
          req_left_d = req_left_q - 1'b1;
        end
        if (resp && resp_left_q != '0) resp_left_d = resp_left_q - 1'b1;
        if ((resp && resp_left_q == BEATS_WIDTH'(1)) || resp_left_q == '0) state_d = S_DONE;
      end
      S_WRITE: begin
        wfire = wdata_valid && (req_left_q != '0);
        if (wfire) begin
          req_addr_d = req_addr_q + 32'd4;
          req_left_d = req_left_q - 1'b1;
        end
        if ((wfire && req_left_q == BEATS_WIDTH'(1)) || req_left_q == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push          = resp;
    pop           = (count_q != '0) && rdata_ready;
    outstanding_d = outstanding_q + CW'(issue) - CW'(resp);
    count_d       = count_q + CW'(push) - CW'(pop);
    wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      handle_q      <= '0;
      req_addr_q    <= '0;
      req_left_q    <= '0;
      resp_left_q   <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      handle_q      <= handle_d;
      req_addr_q    <= req_addr_d;
      req_left_q    <= req_left_d;
      resp_left_q   <= resp_left_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      fifo_data_q[wr_ptr_q] <= dma_readresponse_data;
      fifo_last_q[wr_ptr_q] <= (resp_left_q == BEATS_WIDTH'(1));
    end
  end

  assign cmd_ready              = !RST && (state_q == S_IDLE);
  assign wdata_ready            = !RST && (state_q == S_WRITE) && (req_left_q != '0);
  assign rdata_valid            = !RST && (count_q != '0);
  assign rdata                  = RST ? 32'd0 : fifo_data_q[rd_ptr_q];
  assign rdata_last             = !RST && (count_q != '0) && fifo_last_q[rd_ptr_q];
  assign done                   = !RST && (state_q == S_DONE);
  assign busy                   = !RST && (state_q != S_IDLE);
  assign dma_en_readrequest     = !RST && issue;
  assign dma_readrequest_addr   = RST ? 32'd0 : req_addr_q;
  assign dma_readrequest_handle = RST ? 32'd0 : handle_q;
  assign dma_en_readresponse    = !RST && resp;
  assign dma_en_write32         = !RST && wfire;
  assign dma_write32_addr       = RST ? 32'd0 : req_addr_q;
  assign dma_write32_handle     = RST ? 32'd0 : handle_q;
  assign dma_write32_data       = RST ? 32'd0 : wdata;

endmodule

// File: tb/tb_xsim_dma_burst_client.sv
// Scoreboard bench: stimulus pushes expected requests/writes/read beats, negedge monitors pop
// and compare; a queue-based responder model stands in for the simulation DMA memory.
module tb_xsim_dma_burst_client;
  localparam int D  = 4;
  localparam int BW = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic cmd_valid = 0, cmd_write = 0;
  logic [31:0] cmd_handle = 0, cmd_addr = 0;
  logic [BW-1:0] cmd_beats = 0;
  logic wdata_valid = 0, rdata_ready = 0, dma_rdy_readrequest = 0;
  logic [31:0] wdata = 0;
  logic dma_rdy_readresponse;
  logic [31:0] dma_readresponse_data;
  logic cmd_ready, wdata_ready, rdata_valid, rdata_last, done, busy;
  logic [31:0] rdata;
  logic dma_en_readrequest, dma_en_readresponse, dma_en_write32;
  logic [31:0] dma_readrequest_addr, dma_readrequest_handle;
  logic [31:0] dma_write32_addr, dma_write32_handle, dma_write32_data;

  xsim_dma_burst_client #(.RFIFO_DEPTH(D), .BEATS_WIDTH(BW)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_handle(cmd_handle), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .done(done), .busy(busy),
    .dma_rdy_readrequest(dma_rdy_readrequest), .dma_en_readrequest(dma_en_readrequest),
    .dma_readrequest_addr(dma_readrequest_addr), .dma_readrequest_handle(dma_readrequest_handle),
    .dma_rdy_readresponse(dma_rdy_readresponse), .dma_en_readresponse(dma_en_readresponse),
    .dma_readresponse_data(dma_readresponse_data),
    .dma_en_write32(dma_en_write32), .dma_write32_addr(dma_write32_addr),
    .dma_write32_handle(dma_write32_handle), .dma_write32_data(dma_write32_data)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  int n_req = 0, n_wr = 0, n_pop = 0, n_done = 0, first_rv = -1, last_wr_rel = -1;
  int req_rel[$];
  int rrmode = 0, rqmode = 0, wmode = 0;
  bit wgap_hold = 0;

  logic [63:0] exp_req[$];
  logic [95:0] exp_wr[$];
  logic [32:0] exp_rd[$];
  logic [31:0] wq[$];
  logic [31:0] wvals[$];
  logic [63:0] pend[$];
  logic [31:0] ref_mem[logic [63:0]];
  logic [31:0] resp_mem[logic [63:0]];

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=nothing", name, act);
  endtask

  function automatic logic [31:0] dflt(input logic [63:0] key);
    return 32'hD00D0000 ^ key[31:0] ^ (key[63:32] << 20);
  endfunction

  // Responder: one-cycle request-to-response latency, cleared by the shared reset.
  always @(posedge CLK) begin
    if (RST) begin
      pend.delete();
      dma_rdy_readresponse  <= 1'b0;
      dma_readresponse_data <= '0;
    end else begin
      if (dma_en_readresponse && pend.size() > 0) void'(pend.pop_front());
      if (dma_en_readrequest) pend.push_back({dma_readrequest_handle, dma_readrequest_addr});
      if (dma_en_write32) resp_mem[{dma_write32_handle, dma_write32_addr}] = dma_write32_data;
      dma_rdy_readresponse  <= (pend.size() > 0);
      dma_readresponse_data <= (pend.size() > 0) ?
        (resp_mem.exists(pend[0]) ? resp_mem[pend[0]] : dflt(pend[0])) : 32'd0;
    end
  end

  // Input drivers, updated just after each active edge.
  always @(posedge CLK) begin
    #1;
    rdata_ready         = (rrmode == 2) ? 1'($urandom % 2) : (rrmode == 0);
    dma_rdy_readrequest = (rqmode == 1) ? 1'($urandom % 2) : 1'b1;
    if (wq.size() > 0 && !wgap_hold && (wmode != 2 || ($urandom % 2) == 1)) begin
      wdata_valid = 1'b1;
      wdata       = wq[0];
    end else begin
      wdata_valid = 1'b0;
    end
    wgap_hold = 1'b0;
  end

  // Monitors: every observation at negedge, i.e. what the next active edge will fire.
  always @(negedge CLK) begin
    if (!RST) begin
      if (dma_en_readrequest) begin
        n_req++;
        req_rel.push_back(cyc - acc_cyc);
        if (exp_req.size() == 0) unexpected("req_unexpected", {dma_readrequest_handle, dma_readrequest_addr});
        else chk("req_handle_addr", {dma_readrequest_handle, dma_readrequest_addr}, exp_req.pop_front());
      end
      if (dma_en_write32) begin
        n_wr++;
        last_wr_rel = cyc - acc_cyc;
        if (exp_wr.size() == 0) unexpected("wr_unexpected", {dma_write32_handle, dma_write32_addr});
        else chk("wr_handle_addr_data", {32'd0, dma_write32_addr, dma_write32_data},
                 {32'd0, exp_wr[0][63:0]} | 96'd0);
        if (exp_wr.size() > 0) chk("wr_handle", dma_write32_handle, exp_wr.pop_front() >> 64);
      end
      if (wdata_valid && wdata_ready) begin
        void'(wq.pop_front());
        if (wmode == 1) wgap_hold = 1'b1;
      end
      if (rdata_valid && first_rv < 0) first_rv = cyc - acc_cyc;
      if (rdata_valid && rdata_ready) begin
        n_pop++;
        if (exp_rd.size() == 0) unexpected("rdata_unexpected", {rdata_last, rdata});
        else chk("rdata_last_data", {rdata_last, rdata}, exp_rd.pop_front());
      end
      if (done) n_done++;
    end
  end

  task automatic send_cmd(input bit w, input logic [31:0] h, input logic [31:0] a, input int n);
    logic [31:0] ad, d;
    for (int i = 0; i < n; i++) begin
      ad = a + 32'(4 * i);
      if (w) begin
        d = (wvals.size() > 0) ? wvals.pop_front() : $urandom;
        wq.push_back(d);
        exp_wr.push_back({h, ad, d});
        ref_mem[{h, ad}] = d;
      end else begin
        exp_req.push_back({h, ad});
        exp_rd.push_back({(i == n - 1), (ref_mem.exists({h, ad}) ? ref_mem[{h, ad}] : dflt({h, ad}))});
      end
    end
    @(posedge CLK); #1;
    cmd_valid = 1; cmd_write = w; cmd_handle = h; cmd_addr = a; cmd_beats = BW'(n);
    for (int t = 0; t < 200; t++) begin
      @(negedge CLK);
      if (cmd_ready) begin
        acc_cyc = cyc; first_rv = -1; last_wr_rel = -1; req_rel.delete();
        @(posedge CLK); #1;
        cmd_valid = 0;
        return;
      end
    end
    unexpected("cmd_accept_timeout", 64'(n));
    cmd_valid = 0;
  endtask

  task automatic wait_done(input int budget, output int rel);
    rel = -1;
    for (int t = 0; t < budget; t++) begin
      @(negedge CLK);
      if (done) begin rel = cyc - acc_cyc; return; end
    end
    unexpected("done_timeout", 64'(budget));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, s0, s1, s2;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_ctrl_outputs", {cmd_ready, wdata_ready, rdata_valid, rdata_last, done, busy,
        dma_en_readrequest, dma_en_readresponse, dma_en_write32}, 0);
    chk("reset_addr_outputs", {dma_readrequest_addr, dma_write32_addr}, 0);
    @(posedge CLK); #1 RST = 0;
    @(negedge CLK);
    chk("post_reset_idle", {cmd_ready, busy, rdata_valid, done}, 4'b1000);

    // Directed read with exact latency.
    for (int i = 0; i < 4; i++) begin
      ref_mem[{32'd1, 32'h100 + 32'(4 * i)}]  = 32'hA0 + 32'(i);
      resp_mem[{32'd1, 32'h100 + 32'(4 * i)}] = 32'hA0 + 32'(i);
    end
    send_cmd(0, 32'd1, 32'h100, 4);
    wait_done(50, rel);
    chk("t1_done_cycle", rel, 6);
    chk("t1_req_count", req_rel.size(), 4);
    for (int i = 0; i < req_rel.size() && i < 4; i++) chk("t1_req_cycle", req_rel[i], i + 1);
    chk("t1_first_rdata_cycle", first_rv, 3);
    idle(4);
    chk("t1_drained", exp_rd.size(), 0);

    // Write with one idle cycle between beats, then read back.
    wmode = 1; s0 = n_wr;
    wvals.push_back(32'h11); wvals.push_back(32'h22); wvals.push_back(32'h33);
    send_cmd(1, 32'd2, 32'h200, 3);
    wait_done(50, rel);
    chk("t2_write_count", n_wr - s0, 3);
    chk("t2_done_after_last_write", rel, last_wr_rel + 1);
    wmode = 0;
    send_cmd(0, 32'd2, 32'h200, 3);
    wait_done(50, rel);
    idle(4);
    chk("t2_readback_drained", exp_rd.size(), 0);

    // Backpressure: credit limits in-flight beats to the FIFO depth.
    rrmode = 1; s0 = n_req; s1 = n_pop;
    send_cmd(0, 32'd1, 32'h1000, 10);
    idle(20);
    chk("t3_stalled_req_count", n_req - s0, D);
    rrmode = 0;
    wait_done(200, rel);
    idle(6);
    chk("t3_total_req", n_req - s0, 10);
    chk("t3_total_pop", n_pop - s1, 10);
    chk("t3_drained", exp_rd.size(), 0);

    // Zero-beat bursts in both directions.
    for (int w = 0; w < 2; w++) begin
      s0 = n_req + n_wr;
      send_cmd(1'(w), 32'd3, 32'h300, 0);
      wait_done(20, rel);
      chk("t4_zero_done_cycle", rel, 2);
      @(negedge CLK);
      chk("t4_cmd_ready_after_done", {cmd_ready, done}, 2'b10);
      chk("t4_no_dma_traffic", n_req + n_wr - s0, 0);
    end

    // Address wrap (addresses checked by the request scoreboard).
    s0 = n_req;
    send_cmd(0, 32'd4, 32'hFFFF_FFF8, 4);
    wait_done(50, rel);
    idle(4);
    chk("t5_wrap_req_count", n_req - s0, 4);
    chk("t5_drained", exp_rd.size(), 0);

    // Reset in the middle of a read burst.
    s1 = n_pop;
    send_cmd(0, 32'd5, 32'h500, 6);
    for (int t = 0; t < 50 && (n_pop - s1) < 2; t++) @(negedge CLK);
    @(posedge CLK); #1 RST = 1;
    @(negedge CLK);
    chk("t6_outputs_in_reset", {cmd_ready, rdata_valid, done, busy, dma_en_readrequest}, 0);
    exp_rd.delete(); exp_req.delete();
    @(posedge CLK); #1 RST = 0;
    s2 = n_done;
    @(negedge CLK);
    chk("t6_after_reset", {busy, rdata_valid, cmd_ready}, 3'b001);
    idle(10);
    chk("t6_no_done", n_done - s2, 0);
    send_cmd(0, 32'd5, 32'h600, 2);
    wait_done(50, rel);
    chk("t6_new_read_done_cycle", rel, 4);
    idle(4);
    chk("t6_drained", exp_rd.size(), 0);

    // Randomized traffic.
    rrmode = 2; rqmode = 1; wmode = 2;
    for (int k = 0; k < 40; k++) begin
      logic [31:0] ra;
      ra = $urandom & 32'h0000_03FC;
      send_cmd(1'($urandom % 2), $urandom % 3, ra, $urandom_range(0, 9));
      wait_done(500, rel);
    end
    rrmode = 0; rqmode = 0;
    idle(20);
    chk("final_rd_empty", exp_rd.size(), 0);
    chk("final_req_empty", exp_req.size(), 0);
    chk("final_wr_empty", exp_wr.size() + wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
